// File: rtl/collision_monitor.sv
// rtl/collision_monitor.sv - player/obstacle hit detection, lives and invulnerability FSM
// Optional frame score counter enabled by defining COLLISION_MONITOR_SCORE_EN.
module collision_monitor #(
  parameter int unsigned LIVES_INIT    = 3,
  parameter int unsigned INVULN_FRAMES = 60
) (
  input  logic        clock_25mhz,
  input  logic        reset_n,
  input  logic [12:0] pixel_index,
  input  logic        is_obstacle_hitbox,
  input  logic        is_player_hitbox,
  input  logic        start_btn,
  output logic        game_active,
  output logic [1:0]  lives,
  output logic        collision_pulse,
  output logic        hit_flash,
  output logic        game_over,
  output logic [15:0] score
);

  localparam logic [1:0] LIVES_LOAD = LIVES_INIT[1:0];
  localparam logic [7:0] INV_LOAD   = INVULN_FRAMES[7:0];

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    INVULN  = 2'd2,
    OVER    = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [12:0] pix_prev;
  logic        frame_start;
  logic        overlap_now;
  logic        overlap_latch;
  logic        overlap_latch_nx;
  logic        hit;
  logic [7:0]  inv_cnt;
  logic [7:0]  inv_cnt_nx;
  logic [1:0]  lives_nx;
  logic        pulse_nx;
  logic        start_accept;

  // Frame boundary: raster wrapped back to pixel 0 this cycle.
  assign frame_start  = (pixel_index == 13'd0) && (pix_prev != 13'd0);
  assign overlap_now  = (state == PLAYING) && is_obstacle_hitbox && is_player_hitbox;
  assign hit          = frame_start && (overlap_latch || overlap_now);
  assign start_accept = start_btn && ((state == IDLE) || (state == OVER));

  always_comb begin
    state_nx         = state;
    lives_nx         = lives;
    inv_cnt_nx       = inv_cnt;
    pulse_nx         = 1'b0;
    // Latch collapses any number of overlapping pixels into one hit per frame.
    overlap_latch_nx = (state == PLAYING) && !frame_start && (overlap_latch || overlap_now);
    case (state)
      IDLE, OVER: begin
        if (start_btn) begin
          state_nx         = PLAYING;
          lives_nx         = LIVES_LOAD;
          inv_cnt_nx       = 8'd0;
          overlap_latch_nx = 1'b0;
        end
      end
      PLAYING: begin
        if (hit) begin
          pulse_nx = 1'b1;
          if (lives == 2'd1) begin
            lives_nx = 2'd0;
            state_nx = OVER;
          end else begin
            lives_nx   = lives - 2'd1;
            inv_cnt_nx = INV_LOAD;
            state_nx   = INVULN;
          end
        end
      end
      INVULN: begin
        if (frame_start) begin
          inv_cnt_nx = inv_cnt - 8'd1;
          if (inv_cnt == 8'd1) begin
            state_nx = PLAYING;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      pix_prev        <= 13'd0;
      overlap_latch   <= 1'b0;
      inv_cnt         <= 8'd0;
      lives           <= LIVES_LOAD;
      collision_pulse <= 1'b0;
      game_active     <= 1'b0;
      hit_flash       <= 1'b0;
      game_over       <= 1'b0;
    end else begin
      state           <= state_nx;
      pix_prev        <= pixel_index;
      overlap_latch   <= overlap_latch_nx;
      inv_cnt         <= inv_cnt_nx;
      lives           <= lives_nx;
      collision_pulse <= pulse_nx;
      // Outputs decoded from next state so they align with the state register.
      game_active     <= (state_nx == PLAYING) || (state_nx == INVULN);
      hit_flash       <= (state_nx == INVULN);
      game_over       <= (state_nx == OVER);
    end
  end

`ifdef COLLISION_MONITOR_SCORE_EN
  always_ff @(posedge clock_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      score <= 16'h0000;
    end else if (start_accept) begin
      score <= 16'h0000;
    end else if (frame_start && ((state == PLAYING) || (state == INVULN)) &&
                 (score != 16'hFFFF)) begin
      score <= score + 16'h0001;
    end
  end
`else
  logic unused_start_accept;
  assign unused_start_accept = start_accept;
  assign score               = 16'h0000;
`endif

endmodule

// File: tb/tb_collision_monitor.sv
// tb/tb_collision_monitor.sv - frame-vector bench for collision_monitor
// Score expectations follow COLLISION_MONITOR_SCORE_EN.
module tb_collision_monitor;

  logic        clock_25mhz = 1'b0;
  logic        reset_n = 1'b0;
  logic [12:0] pixel_index = 13'd0;
  logic        is_obstacle_hitbox = 1'b0;
  logic        is_player_hitbox = 1'b0;
  logic        start_btn = 1'b0;
  logic        game_active;
  logic [1:0]  lives;
  logic        collision_pulse;
  logic        hit_flash;
  logic        game_over;
  logic [15:0] score;

  collision_monitor #(.LIVES_INIT(3), .INVULN_FRAMES(60)) dut (
    .clock_25mhz       (clock_25mhz),
    .reset_n           (reset_n),
    .pixel_index       (pixel_index),
    .is_obstacle_hitbox(is_obstacle_hitbox),
    .is_player_hitbox  (is_player_hitbox),
    .start_btn         (start_btn),
    .game_active       (game_active),
    .lives             (lives),
    .collision_pulse   (collision_pulse),
    .hit_flash         (hit_flash),
    .game_over         (game_over),
    .score             (score)
  );

  always #20 clock_25mhz = ~clock_25mhz;

  typedef struct {
    int          ovl;
    bit          ovl_fs;
    bit          start_mid;
    bit          start_fs;
    bit          rst_before;
    bit          e_pulse;
    logic [1:0]  e_lives;
    bit          e_flash;
    bit          e_over;
    bit          e_active;
    logic [15:0] e_score;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  function automatic logic [15:0] exp_score(input logic [15:0] s);
`ifdef COLLISION_MONITOR_SCORE_EN
    return s;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
  endtask

  function automatic void add(input int ovl, input bit ovl_fs, input bit sm, input bit sf,
                              input bit rb, input bit p, input logic [1:0] l, input bit f,
                              input bit o, input bit a, input logic [15:0] s);
    vec_t v;
    v.ovl = ovl; v.ovl_fs = ovl_fs; v.start_mid = sm; v.start_fs = sf; v.rst_before = rb;
    v.e_pulse = p; v.e_lives = l; v.e_flash = f; v.e_over = o; v.e_active = a; v.e_score = s;
    tbl.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clock_25mhz);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_active"}, 32'(game_active), 0);
    check({tag, "_lives"}, 32'(lives), 3);
    check({tag, "_pulse"}, 32'(collision_pulse), 0);
    check({tag, "_flash"}, 32'(hit_flash), 0);
    check({tag, "_over"}, 32'(game_over), 0);
    check({tag, "_score"}, 32'(score), 0);
  endtask

  // One short frame: pixels 1..7 then pixel 0, which is the frame_start cycle.
  task automatic run_vec(input vec_t v);
    vec_t e;
    if (v.rst_before) begin
      #5 reset_n = 1'b0;
      #1;
      check_reset_values("async_rst");
      tick();
      reset_n = 1'b1;
    end
    for (int p = 1; p < 8; p++) begin
      pixel_index        = 13'(p);
      is_obstacle_hitbox = (p <= v.ovl);
      is_player_hitbox   = (p <= v.ovl);
      start_btn          = (p == 1) && v.start_mid;
      tick();
      start_btn = 1'b0;
      if (p == 1) begin
        check("pulse_width", 32'(collision_pulse), 0);
        if (v.start_mid) begin
          check("start_active", 32'(game_active), 1);
          check("start_lives", 32'(lives), 3);
          check("start_over", 32'(game_over), 0);
        end
      end
    end
    pixel_index        = 13'd0;
    is_obstacle_hitbox = v.ovl_fs;
    is_player_hitbox   = v.ovl_fs;
    start_btn          = v.start_fs;
    exp_q.push_back(v);
    tick();
    start_btn          = 1'b0;
    is_obstacle_hitbox = 1'b0;
    is_player_hitbox   = 1'b0;
    e = exp_q.pop_front();
    check("pulse", 32'(collision_pulse), 32'(e.e_pulse));
    check("lives", 32'(lives), 32'(e.e_lives));
    check("flash", 32'(hit_flash), 32'(e.e_flash));
    check("over", 32'(game_over), 32'(e.e_over));
    check("active", 32'(game_active), 32'(e.e_active));
    check("score", 32'(score), 32'(exp_score(e.e_score)));
  endtask

  initial begin
    // ovl, ovl_fs, start_mid, start_fs, rst_before | pulse, lives, flash, over, active, score
    add(5, 0, 0, 0, 0, 0, 2'd3, 0, 0, 0, 16'd0);
    add(0, 0, 1, 0, 0, 0, 2'd3, 0, 0, 1, 16'd1);
    for (int k = 2; k <= 10; k++) add(0, 0, 0, 0, 0, 0, 2'd3, 0, 0, 1, 16'(k));
    add(5, 0, 0, 0, 0, 1, 2'd2, 1, 0, 1, 16'd11);
    for (int k = 1; k <= 60; k++) add(5, 0, 0, 0, 0, 0, 2'd2, (k < 60), 0, 1, 16'(11 + k));
    add(5, 0, 0, 0, 0, 1, 2'd1, 1, 0, 1, 16'd72);
    for (int k = 1; k <= 60; k++) add(0, 0, 0, 0, 0, 0, 2'd1, (k < 60), 0, 1, 16'(72 + k));
    add(1, 0, 0, 0, 0, 1, 2'd0, 0, 1, 0, 16'd133);
    add(5, 0, 0, 0, 0, 0, 2'd0, 0, 1, 0, 16'd133);
    add(0, 0, 0, 1, 0, 0, 2'd3, 0, 0, 1, 16'd0);
    add(0, 1, 0, 0, 0, 1, 2'd2, 1, 0, 1, 16'd1);
    add(5, 0, 0, 0, 1, 0, 2'd3, 0, 0, 0, 16'd0);
    add(5, 0, 0, 0, 0, 0, 2'd3, 0, 0, 0, 16'd0);
    add(0, 0, 1, 0, 0, 0, 2'd3, 0, 0, 1, 16'd1);

    tick();
    tick();
    check_reset_values("reset");
    reset_n = 1'b1;
    tick();

    foreach (tbl[i]) run_vec(tbl[i]);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/collision_monitor.md
COLLISION_MONITOR -- requirements
Module: collision_monitor

Interface
REQ-001 SHALL have parameter LIVES_INIT, default 3, lives loaded at game start (range 1..3).
REQ-002 SHALL have parameter INVULN_FRAMES, default 60, frames of collision immunity after a hit (range 1..255).
REQ-003 SHALL have port clock_25mhz  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port pixel_index  input  13  current OLED pixel (0..6143, 96x64 raster).
REQ-006 SHALL have port is_obstacle_hitbox  input  1  obstacle generator reports an obstacle at pixel_index.
REQ-007 SHALL have port is_player_hitbox  input  1  player sprite reports the player at pixel_index.
REQ-008 SHALL have port start_btn  input  1  synchronous, debounced, single-cycle start pulse.
REQ-009 SHALL have port game_active  output  1  high in PLAYING and INVULN; feeds the obstacle generators.
REQ-010 SHALL have port lives  output  2  remaining lives.
REQ-011 SHALL have port collision_pulse  output  1  one-cycle strobe per counted hit.
REQ-012 SHALL have port hit_flash  output  1  high in INVULN (player blink).
REQ-013 SHALL have port game_over  output  1  high in OVER.
REQ-014 SHALL have port score  output  16  frames survived (see Configuration).

Function
REQ-015 SHALL register pixel_index into pix_prev; frame_start = (pixel_index==0) && (pix_prev!=0).
REQ-016 SHALL implement FSM states IDLE, PLAYING, INVULN, OVER, all registered outputs, no combinational output paths.
REQ-017 SHALL set overlap_latch in any cycle with state==PLAYING && is_obstacle_hitbox && is_player_hitbox; overlap_latch SHALL remain low in all other states.
REQ-018 SHALL, on a frame_start cycle, evaluate hit = overlap_latch || current-cycle overlap, then clear overlap_latch in that same cycle.
REQ-019 SHALL transition IDLE or OVER -> PLAYING on start_btn, loading lives=LIVES_INIT, clearing overlap_latch and the invulnerability counter.
REQ-020 SHALL, in PLAYING with hit at frame_start: pulse collision_pulse for exactly one cycle at the next edge; if lives==1 set lives=0 and go to OVER, else decrement lives, load inv_cnt=INVULN_FRAMES, go to INVULN.
REQ-021 SHALL, in INVULN, decrement inv_cnt (8-bit) on each frame_start; on the frame_start that finds inv_cnt==1, return to PLAYING.
REQ-022 SHALL ignore start_btn in PLAYING and INVULN.
REQ-023 SHALL give start_btn priority over a coincident frame_start in OVER or IDLE.
REQ-024 SHALL count at most one hit per frame, regardless of how many overlapping pixels occur.
REQ-025 SHALL hold lives, game_over, and score constant in OVER until start_btn.

Reset
REQ-026 SHALL, when reset_n is low, asynchronously force: state=IDLE, lives=LIVES_INIT, game_active=0, collision_pulse=0, hit_flash=0, game_over=0, score=0, overlap_latch=0, inv_cnt=0, pix_prev=0.
REQ-027 SHALL, on reset asserted mid-game, abandon the game, and SHALL require start_btn after release to resume play.

Configuration
REQ-028 SHALL, with macro COLLISION_MONITOR_SCORE_EN defined, increment score on each frame_start in PLAYING or INVULN (saturating at 16'hFFFF) and clear it on start_btn.
REQ-029 SHALL, without COLLISION_MONITOR_SCORE_EN, tie score to 16'h0000 and instantiate no score counter.

Verification
REQ-030 SHALL cover: reset then start_btn pulse -> game_active=1 next cycle, lives=3, game_over=0.
REQ-031 SHALL cover: in PLAYING, 5 overlapping pixels in one frame -> single collision_pulse at the next frame_start, lives 3->2, hit_flash=1.
REQ-032 SHALL cover: overlaps every frame during INVULN (INVULN_FRAMES=60) -> no pulse, lives stays 2, hit_flash drops after the 60th frame_start, then the next overlapped frame gives lives=1.
REQ-033 SHALL cover: a hit with lives=1 -> lives=0, game_over=1, game_active=0; then start_btn coincident with frame_start -> PLAYING, lives=3.
REQ-034 SHALL cover: reset_n pulsed low mid-INVULN -> all outputs at reset values immediately, and IDLE is held until start_btn.
REQ-035 SHALL cover, with COLLISION_MONITOR_SCORE_EN: 10 frames without overlap -> score=10; after game over, score frozen at its last value; with the macro undefined, score=0 throughout.
